// File: rtl/mult_unit.sv
// -----------------------------------------------------------------------------
// mult_unit
//   Multi-cycle shift-add multiplier. Operands are latched on an accepted
//   start. Signed operands are reduced to their magnitudes, multiplied
//   unsigned over n steps, and the product is negated at the end when the
//   operand signs differ. The hi/lo outputs are registered and hold until
//   the next completed multiply.
// -----------------------------------------------------------------------------
module mult_unit #(
    parameter int unsigned n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         is_signed,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] hi,
    output logic [n-1:0] lo
);

    localparam int unsigned CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [n-1:0]    mcand_q;
    logic [n-1:0]    mplier_q;
    logic            sign_q;
    logic [CW-1:0]   count_q;
    logic [2*n-1:0]  acc_q;
    logic            busy_q;
    logic            done_q;
    logic [n-1:0]    hi_q;
    logic [n-1:0]    lo_q;

    logic [n:0]      sum;
    logic [2*n-1:0]  acc_d;
    logic [n-1:0]    mplier_d;
    logic [2*n-1:0]  prod_d;
    logic [n-1:0]    a_mag;
    logic [n-1:0]    b_mag;
    logic            sign_d;

    // One shift-add step, the final signed fix-up, and operand magnitudes.
    // NOTE: every signal driven here gets an unconditional value first, so no latch can be inferred.
    always_comb begin
        sum      = {1'b0, acc_q[2*n-1:n]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        acc_d    = {sum, acc_q[n-1:1]};
        mplier_d = mplier_q >> 1;
        prod_d   = sign_q ? -acc_d : acc_d;
        // The most negative value maps to itself, which is its correct
        // magnitude once the word is read as unsigned.
        a_mag    = (is_signed && a[n-1]) ? -a : a;
        b_mag    = (is_signed && b[n-1]) ? -b : b;
        sign_d   = is_signed & (a[n-1] ^ b[n-1]);
    end

    // Control FSM with registered busy/done and result outputs.
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            count_q  <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a_mag;
                        mplier_q <= b_mag;
                        sign_q   <= sign_d;
                        count_q  <= CW'(n - 1);
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_q - CW'(1);
                    if (count_q == '0) begin
                        hi_q    <= prod_d[2*n-1:n];
                        lo_q    <= prod_d[n-1:0];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_unit
//   Directed vectors with hand-computed products for mult_unit (n = 16).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_mult_unit;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    mult_unit #(.n(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; leaves start low afterwards.
    task automatic start_mult(input logic sg, input logic [N-1:0] va, input logic [N-1:0] vb);
        is_signed = sg;
        a         = va;
        b         = vb;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // Counts edges until busy drops, bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Full multiply: accept, scramble the inputs, wait, check latency and result.
    task automatic run_case(input string tag, input logic sg, input logic [N-1:0] va,
                            input logic [N-1:0] vb, input logic [N-1:0] exp_hi,
                            input logic [N-1:0] exp_lo);
        int cyc;
        start_mult(sg, va, vb);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        a         = 16'hA5A5;
        b         = 16'h5A5A;
        is_signed = ~sg;
        wait_done(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'd16);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_hi"}, 32'(hi), 32'(exp_hi));
        check({tag, "_lo"}, 32'(lo), 32'(exp_lo));
        tick();
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_hi_hold"}, 32'(hi), 32'(exp_hi));
        check({tag, "_lo_hold"}, 32'(lo), 32'(exp_lo));
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int done_at;
        logic [N-1:0] cap_hi;
        logic [N-1:0] cap_lo;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        a         = '0;
        b         = '0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", 32'(hi), 32'd0);
        check("rst_lo", 32'(lo), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        run_case("u3x5",      1'b0, 16'h0003, 16'h0005, 16'h0000, 16'h000F);
        run_case("s_m3x5",    1'b1, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1);
        run_case("u_ffxff",   1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
        run_case("s_min_min", 1'b1, 16'h8000, 16'h8000, 16'h4000, 16'h0000);
        run_case("s_min_x1",  1'b1, 16'h8000, 16'h0001, 16'hFFFF, 16'h8000);

        // Start pulsed while busy must be ignored.
        start_mult(1'b0, 16'h0002, 16'h0002);
        done_cnt = 0;
        done_at  = 0;
        cap_hi   = '1;
        cap_lo   = '1;
        for (int k = 1; k <= 30; k++) begin
            if (k == 5) begin
                a     = 16'h0007;
                b     = 16'h0007;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_at = k;
                    cap_hi  = hi;
                    cap_lo  = lo;
                end
            end
        end
        check("ign_done_pulses", 32'(done_cnt), 32'd1);
        check("ign_done_at", 32'(done_at), 32'd16);
        check("ign_hi", 32'(cap_hi), 32'h0);
        check("ign_lo", 32'(cap_lo), 32'h4);

        // Asynchronous reset in the middle of a multiply.
        start_mult(1'b0, 16'h0009, 16'h0009);
        for (int k = 0; k < 7; k++) tick();
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_hi", 32'(hi), 32'd0);
        check("rst_mid_lo", 32'(lo), 32'd0);
        tick();
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check("rst_mid_no_done", 32'(done_cnt), 32'd0);
        run_case("post_rst_6x7", 1'b0, 16'h0006, 16'h0007, 16'h0000, 16'h002A);

        // Back-to-back: start held high straight through the DONE cycle.
        is_signed = 1'b0;
        a         = 16'h0003;
        b         = 16'h0004;
        start     = 1'b1;
        tick();
        check("b2b_busy1", 32'(busy), 32'd1);
        wait_done(cyc);
        check("b2b_latency1", 32'(cyc), 32'd16);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_lo1", 32'(lo), 32'h000C);
        a = 16'h0005;
        b = 16'h0006;
        tick();
        start = 1'b0;
        check("b2b_busy2", 32'(busy), 32'd1);
        check("b2b_done_drop", 32'(done), 32'd0);
        check("b2b_lo_kept", 32'(lo), 32'h000C);
        wait_done(cyc);
        check("b2b_latency2", 32'(cyc), 32'd16);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_hi2", 32'(hi), 32'h0000);
        check("b2b_lo2", 32'(lo), 32'h001E);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
